// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter
//   Shares the single physical-memory port between the I-cache and the D-cache.
//   A requester is granted from IDLE. The memory port is then driven from
//   copies of its address, data and direction taken at the grant edge.
//   A completion pulse from memory returns the arbiter to IDLE through one
//   RECOVER cycle. Simultaneous requests alternate I/D (round-robin).
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   i_read, i_address                I-cache line read request (held until i_resp)
//   i_rdata, i_resp                  I-cache returned line / completion pulse
//   d_read, d_write, d_address,      D-cache read / writeback request (held until d_resp)
//   d_wdata
//   d_rdata, d_resp                  D-cache returned line / completion pulse
//   pmem_read, pmem_write,           memory strobes, address, write line
//   pmem_address, pmem_wdata
//   pmem_rdata, pmem_resp            memory read line / completion pulse
module lc3b_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RECOVER} state_t;

  state_t            r_state, w_next;
  logic              r_last_g;   // 0: I-cache granted last, 1: D-cache granted last
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_wr;

  logic w_i_req, w_d_req, w_grant_i, w_grant_d;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Grants only leave IDLE. Because RECOVER always precedes IDLE, a request
  // still held in the cycle after its resp is seen in RECOVER and ignored.
  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    case (r_state)
      IDLE: begin
        // On a tie, the cache not named by r_last_g wins.
        if (w_i_req && (!w_d_req || r_last_g)) begin
          w_grant_i = 1'b1;
          w_next    = BUSY_I;
        end else if (w_d_req) begin
          w_grant_d = 1'b1;
          w_next    = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: if (pmem_resp) w_next = RECOVER;
      RECOVER:        w_next = IDLE;
      default:        w_next = IDLE;
    endcase
  end

  // Copies of the winner's request. Later request changes cannot reach memory.
  // A D-cache read+write is taken as a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_g <= 1'b1;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wr     <= 1'b0;
    end else if (w_grant_i) begin
      r_last_g <= 1'b0;
      r_addr   <= i_address;
      r_wdata  <= d_wdata;
      r_wr     <= 1'b0;
    end else if (w_grant_d) begin
      r_last_g <= 1'b1;
      r_addr   <= d_address;
      r_wdata  <= d_wdata;
      r_wr     <= d_write;
    end
  end

  // Strobes decode from the registered state, so an async reset drops them at once.
  assign pmem_read    = (r_state == BUSY_I) | ((r_state == BUSY_D) & ~r_wr);
  assign pmem_write   = (r_state == BUSY_D) & r_wr;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;

  // A stray pmem_resp in IDLE or RECOVER reaches neither cache.
  assign i_resp  = (r_state == BUSY_I) & pmem_resp;
  assign d_resp  = (r_state == BUSY_D) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

`ifndef SYNTHESIS
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write));
`endif

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
module tb_lc3b_mem_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  always #5 clk = ~clk;

  lc3b_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // Reference model: who owns memory (0 none, 1 I, 2 D), whether the
  // post-completion dead cycle is pending, and the captured request.
  int            m_who    = 0;
  bit            m_dead   = 1'b0;
  bit            m_last_d = 1'b1;
  logic [AW-1:0] m_addr   = '0;
  logic [LW-1:0] m_wdata  = '0;
  bit            m_wr     = 1'b0;
  int            grants[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_who <= 0; m_dead <= 1'b0; m_last_d <= 1'b1;
      m_addr <= '0; m_wdata <= '0; m_wr <= 1'b0;
    end else if (m_dead) begin
      m_dead <= 1'b0;
    end else if (m_who != 0) begin
      if (pmem_resp) begin m_who <= 0; m_dead <= 1'b1; end
    end else if (i_read && (!(d_read || d_write) || m_last_d)) begin
      m_who <= 1; m_last_d <= 1'b0; m_addr <= i_address; m_wdata <= d_wdata; m_wr <= 1'b0;
      grants.push_back(1);
    end else if (d_read || d_write) begin
      m_who <= 2; m_last_d <= 1'b1; m_addr <= d_address; m_wdata <= d_wdata; m_wr <= d_write;
      grants.push_back(2);
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin n_err++; $display("FAIL %s got=%0h want=%0h", nm, act, exp); end
  endtask
  task automatic chka(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin n_err++; $display("FAIL %s got=%0h want=%0h", nm, act, exp); end
  endtask
  task automatic chkw(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin n_err++; $display("FAIL %s got=%0h want=%0h", nm, act, exp); end
  endtask
  task automatic chki(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin n_err++; $display("FAIL %s got=%0d want=%0d", nm, act, exp); end
  endtask

  // Stimulus agents and the per-cycle comparison, all advanced by step().
  int            mem_lat_fix = 0;   // 0 selects a random 1..4 latency
  bit            mem_fill_en = 1'b0;
  logic [LW-1:0] mem_fill    = '0;
  bit            spur_en     = 1'b0;
  bit            armed       = 1'b0;
  int            cnt         = 0;
  int            i_mode      = 0;   // 0 manual, 1 random, 2 persistent
  int            d_mode      = 0;
  bit            i_got       = 1'b0;
  bit            d_got       = 1'b0;
  bit            prev_rd     = 1'b0;
  int            n_rd_rise   = 0;
  int            n_iresp     = 0;
  int            n_dresp     = 0;

  task automatic step();
    logic e_rd, e_wr;
    @(negedge clk);
    pmem_rdata = mem_fill_en ? mem_fill : {$urandom(), $urandom(), $urandom(), $urandom()};
    pmem_resp  = 1'b0;
    if (!rst_n) armed = 1'b0;
    else if (pmem_read || pmem_write) begin
      if (!armed) begin
        armed = 1'b1;
        cnt   = (mem_lat_fix != 0) ? mem_lat_fix : int'($urandom_range(1, 4));
      end else begin
        cnt--;
        if (cnt == 0) begin pmem_resp = 1'b1; armed = 1'b0; end
      end
    end else if (spur_en && $urandom_range(0, 3) == 0) pmem_resp = 1'b1;

    if (i_mode != 0) begin
      if (i_got) i_read = 1'b0;
      else if (!i_read) begin
        if (i_mode == 2 || $urandom_range(0, 2) == 0) begin i_read = 1'b1; i_address = 16'($urandom()); end
      end else if (i_mode == 1 && $urandom_range(0, 3) == 0) i_address = 16'($urandom());
    end
    if (d_mode != 0) begin
      if (d_got) begin d_read = 1'b0; d_write = 1'b0; end
      else if (!d_read && !d_write) begin
        if (d_mode == 2 || $urandom_range(0, 2) == 0) begin
          if (d_mode == 1 && $urandom_range(0, 1) == 1) d_write = 1'b1; else d_read = 1'b1;
          d_address = 16'($urandom());
          d_wdata   = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
      end else if (d_mode == 1 && $urandom_range(0, 3) == 0) begin
        d_address = 16'($urandom());
        d_wdata   = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end

    #1;
    e_rd = (m_who == 1) || (m_who == 2 && !m_wr);
    e_wr = (m_who == 2) && m_wr;
    chk1("pmem_read", pmem_read, e_rd);
    chk1("pmem_write", pmem_write, e_wr);
    chka("pmem_address", pmem_address, m_addr);
    chkw("pmem_wdata", pmem_wdata, m_wdata);
    chk1("i_resp", i_resp, (m_who == 1) && pmem_resp);
    chk1("d_resp", d_resp, (m_who == 2) && pmem_resp);
    chkw("i_rdata", i_rdata, pmem_rdata);
    chkw("d_rdata", d_rdata, pmem_rdata);
    i_got = i_resp;
    d_got = d_resp;
    if (i_resp) n_iresp++;
    if (d_resp) n_dresp++;
    if (pmem_read && !prev_rd) n_rd_rise++;
    prev_rd = pmem_read;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int ir0, dr0, r0, g0, kat;
    bit got;

    // Reset state
    repeat (3) step();
    chk1("rst_pmem_read", pmem_read, 1'b0);
    chk1("rst_pmem_write", pmem_write, 1'b0);
    chka("rst_pmem_address", pmem_address, 16'h0000);
    chkw("rst_pmem_wdata", pmem_wdata, '0);
    rst_n = 1'b1;
    repeat (2) step();

    // Single I-cache read, latency 3
    mem_lat_fix = 3; mem_fill_en = 1'b1; mem_fill = {16{8'hA5}};
    ir0 = n_iresp; dr0 = n_dresp;
    i_address = 16'h0040; i_read = 1'b1;
    step();
    chk1("t1_strobe", pmem_read, 1'b1);
    chka("t1_addr", pmem_address, 16'h0040);
    got = 1'b0; kat = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      if (i_resp) begin got = 1'b1; kat = k; chkw("t1_rdata", i_rdata, {16{8'hA5}}); end
    end
    chki("t1_resp_latency", kat, 2);
    step();
    i_read = 1'b0;
    chk1("t1_recover_no_strobe", pmem_read, 1'b0);
    repeat (2) step();
    chki("t1_iresp_count", n_iresp - ir0, 1);
    chki("t1_dresp_count", n_dresp - dr0, 0);

    // D-cache writeback
    mem_fill_en = 1'b0;
    dr0 = n_dresp;
    d_address = 16'h1230; d_wdata = 128'h0123456789ABCDEF0123456789ABCDEF; d_write = 1'b1;
    step();
    chk1("t2_write", pmem_write, 1'b1);
    chk1("t2_no_read", pmem_read, 1'b0);
    chka("t2_addr", pmem_address, 16'h1230);
    chkw("t2_wdata", pmem_wdata, 128'h0123456789ABCDEF0123456789ABCDEF);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin step(); got = d_resp; end
    chk1("t2_dresp_seen", got, 1'b1);
    step();
    d_write = 1'b0;
    repeat (2) step();
    chki("t2_dresp_count", n_dresp - dr0, 1);

    // Simultaneous persistent requests after reset: I, D, I, D
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    mem_lat_fix = 2;
    g0 = grants.size();
    i_mode = 2; d_mode = 2;
    for (int k = 0; k < 100 && grants.size() < g0 + 4; k++) step();
    chki("t3_grant_cnt", grants.size() - g0 >= 4 ? 4 : grants.size() - g0, 4);
    chki("t3_g0", grants.size() > g0     ? grants[g0]     : -1, 1);
    chki("t3_g1", grants.size() > g0 + 1 ? grants[g0 + 1] : -1, 2);
    chki("t3_g2", grants.size() > g0 + 2 ? grants[g0 + 2] : -1, 1);
    chki("t3_g3", grants.size() > g0 + 3 ? grants[g0 + 3] : -1, 2);
    i_mode = 0; d_mode = 0;
    i_read = 1'b0; d_read = 1'b0;
    repeat (10) step();

    // Stale request held one extra cycle past i_resp
    mem_lat_fix = 3;
    r0 = n_rd_rise;
    i_address = 16'h0100; i_read = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin step(); got = i_resp; end
    chk1("t4_resp_seen", got, 1'b1);
    step();
    chk1("t4_recover_no_read", pmem_read, 1'b0);
    step();
    chk1("t4_no_regrant", pmem_read, 1'b0);
    i_read = 1'b0;
    repeat (4) step();
    chki("t4_access_count", n_rd_rise - r0, 1);

    // Address change mid-access
    i_address = 16'h0040; i_read = 1'b1;
    step();
    i_address = 16'h0080;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      chka("t5_addr_held", pmem_address, 16'h0040);
      step();
      got = i_resp;
    end
    chk1("t5_resp_seen", got, 1'b1);
    step();
    i_read = 1'b0;
    repeat (2) step();

    // Reset 2 cycles into a D-cache read
    mem_lat_fix = 4;
    dr0 = n_dresp;
    d_address = 16'h0300; d_read = 1'b1;
    repeat (3) step();
    chk1("t6_read_active", pmem_read, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("t6_async_drop", pmem_read, 1'b0);
    chk1("t6_no_dresp", d_resp, 1'b0);
    i_address = 16'h0200; i_read = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    g0 = grants.size();
    step();
    chki("t6_first_grant_i", grants.size() > g0 ? grants[g0] : -1, 1);
    chk1("t6_i_strobe", pmem_read, 1'b1);
    chka("t6_i_addr", pmem_address, 16'h0200);
    chki("t6_dresp_count", n_dresp - dr0, 0);

    // Randomized traffic with random latency and stray memory responses
    mem_lat_fix = 0; spur_en = 1'b1;
    i_mode = 1; d_mode = 1;
    g0 = grants.size();
    repeat (3000) step();
    chk1("rand_progress", (grants.size() - g0) > 100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/lc3b_mem_arbiter.md
Name: lc3b_mem_arbiter

Overview:
- Shares the single physical-memory port between the instruction cache and the data cache of the pipelined LC-3b core.
- Each cache issues cache-line reads or writebacks using a level-held request / one-cycle response handshake.
- The arbiter grants one requester at a time and drives the memory port from registered copies of that requester's address and data.
- When both caches request together, grants alternate round-robin so neither cache starves.

Parameters:
- ADDR_W, 16, physical byte-address width (lc3b_word).
- LINE_W, 128, cache-line width in bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  I-cache line read request; held until i_resp
- i_address  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle I-cache completion pulse
- d_read  in  1  D-cache line read request; held until d_resp
- d_write  in  1  D-cache writeback request; held until d_resp
- d_address  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache writeback line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle D-cache completion pulse
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  ADDR_W  memory address
- pmem_wdata  out  LINE_W  memory write line
- pmem_rdata  in  LINE_W  memory read line
- pmem_resp  in  1  memory completion pulse

Behaviour:
- State machine states:
  - IDLE: no memory access.
  - BUSY_I: serving the I-cache; access type is always read.
  - BUSY_D: serving the D-cache; access type is read or write.
  - RECOVER: one dead cycle after every completion.
- Additional state:
  - last_g, 1 bit: 0 = I-cache granted last, 1 = D-cache granted last.
  - Latched registers: addr_q, wdata_q, wr_q.
- Reset, asynchronous, while rst_n=0:
  - state=IDLE, last_g=1 (first tie goes to the I-cache).
  - addr_q=0, wdata_q=0, wr_q=0.
  - pmem_read=0, pmem_write=0, i_resp=0, d_resp=0.
  - pmem_address=0, pmem_wdata=0.
- IDLE transitions, evaluated at the clock edge:
  - I-cache requesting only -> BUSY_I.
  - D-cache requesting only -> BUSY_D.
  - Both requesting -> grant the cache not named by last_g.
  - Neither requesting -> stay in IDLE.
  - On grant: latch addr_q and wdata_q; set wr_q=d_write for a D-cache grant, 0 for an I-cache grant; update last_g.
- Memory strobes:
  - pmem_read = (BUSY_I) | (BUSY_D & ~wr_q).
  - pmem_write = BUSY_D & wr_q.
  - pmem_address=addr_q and pmem_wdata=wdata_q; both are registered and do not change during the access.
  - Grant-to-strobe latency is 1 cycle from the request cycle.
- Completion, combinational:
  - i_resp = BUSY_I & pmem_resp.
  - d_resp = BUSY_D & pmem_resp.
  - i_rdata = d_rdata = pmem_rdata, passed through unconditionally.
  - Caches sample rdata only on their own resp.
- On pmem_resp in BUSY_I or BUSY_D -> RECOVER. RECOVER always -> IDLE.
  - The dead cycle absorbs a request that is still asserted for the cycle after resp, so a stale request is never re-granted.
- Requests that change in the middle of a grant are ignored; only the latched values drive memory.
- d_read and d_write both asserted is illegal and is treated as a write. Under simulation an assertion fires.
- pmem_resp while in IDLE or RECOVER is ignored, and neither resp output is asserted.
- rst_n falling mid-access:
  - Strobes drop immediately and state returns to IDLE.
  - No resp is issued for the aborted access.
- Minimum occupancy per access: grant cycle + memory latency + 1 RECOVER cycle.

Test Plan:
- Single I-cache read:
  - Stimulus: i_read=1, i_address=16'h0040; pmem_resp pulses 3 cycles after pmem_read rises, with pmem_rdata=128'hA5...A5.
  - Required: pmem_read=1 and pmem_address=16'h0040 from cycle+1; i_resp=1 for exactly one cycle with i_rdata=128'hA5...A5; d_resp stays 0; state in RECOVER, then IDLE.
- D-cache writeback:
  - Stimulus: d_write=1, d_address=16'h1230, d_wdata=128'h0123...CDEF.
  - Required: pmem_write=1 and pmem_read=0, with pmem_wdata/pmem_address matching the stimulus; d_resp pulses on pmem_resp.
- Simultaneous requests after reset:
  - Stimulus: i_read=1 and d_read=1 held continuously.
  - Required: grant order is I, D, I, D. Each requester drops its request on resp and reasserts on the next cycle. No second grant occurs in the same RECOVER cycle.
- Stale request:
  - Stimulus: the I-cache holds i_read one cycle past i_resp.
  - Required: no new pmem_read in the RECOVER cycle; at most one access is issued.
- Address change mid-access:
  - Stimulus: i_address toggles from 16'h0040 to 16'h0080 while in BUSY_I.
  - Required: pmem_address stays 16'h0040 until resp.
- Reset during a D-cache read:
  - Stimulus: rst_n=0 asserted 2 cycles into the access.
  - Required: pmem_read drops immediately (asynchronously) and d_resp is never asserted. After release, a simultaneous request is granted to the I-cache first.
